// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, FSM state type and decode helpers for the pipeline
// controller slice.
package pipe_ctrl_pkg;

   localparam logic        STOP          = 1'b1;
   localparam logic        NO_STOP       = 1'b0;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
   localparam logic        RST_ENABLE    = 1'b0;
   localparam logic [31:0] EXC_ERET      = 32'h0000_000e;
   localparam logic [31:0] EXC_VECTOR    = 32'h0000_0020;
   localparam int          STALL_WD_LIM  = 1023;

   localparam logic [5:0]  STALL_NONE    = 6'b000000;
   localparam logic [5:0]  STALL_IF      = 6'b000011;
   localparam logic [5:0]  STALL_ID      = 6'b000111;
   localparam logic [5:0]  STALL_EX      = 6'b001111;
   localparam logic [5:0]  STALL_MEM     = 6'b011111;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // Later stages win: holding them implies holding everything upstream.
   function automatic logic [5:0] stall_mask(
      input logic req_if,
      input logic req_id,
      input logic req_ex,
      input logic req_mem
   );
      logic [5:0] m;
      m = STALL_NONE;
      priority case (1'b1)
         req_mem: m = STALL_MEM;
         req_ex:  m = STALL_EX;
         req_id:  m = STALL_ID;
         req_if:  m = STALL_IF;
         default: m = STALL_NONE;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] redirect(
      input logic [31:0] code,
      input logic [31:0] epc
   );
      return (code == EXC_ERET) ? epc : EXC_VECTOR;
   endfunction

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// Stall/flush statistics counters and the consecutive-stall watchdog.
module pipe_ctrl_cnt
   import pipe_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_any,
   input  logic        flush,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count,
   output logic        stall_timeout
);

   localparam logic [9:0] WD_LIM = 10'(STALL_WD_LIM);

   logic [9:0] wd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (rst_n == RST_ENABLE) begin
         stall_cycles  <= ZERO_WORD;
         flush_count   <= 16'h0000;
         wd            <= 10'd0;
         stall_timeout <= 1'b0;
      end else begin
         if (stall_any)
            stall_cycles <= stall_cycles + 32'd1;

         if (flush && flush_count != 16'hFFFF)
            flush_count <= flush_count + 16'd1;

         if (!stall_any)
            wd <= 10'd0;
         else if (wd != WD_LIM)
            wd <= wd + 10'd1;

         // Flag rises on the edge where the count lands on the limit.
         if (stall_any && wd >= WD_LIM - 10'd1)
            stall_timeout <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall mask decode, exception flush and
// redirect, with a drain state for exceptions behind a busy data bus.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count,
   output logic        stall_timeout
);

   state_t      state;
   logic [31:0] pend_code;
   logic [31:0] pend_epc;
   logic        exc;

   assign exc = (excepttype != ZERO_WORD);

   always_comb begin
      stall  = STALL_NONE;
      flush  = 1'b0;
      new_pc = ZERO_WORD;
      if (rst_n != RST_ENABLE) begin
         unique case (state)
            RUN: begin
               if (exc && !stallreq_mem) begin
                  flush  = 1'b1;
                  new_pc = redirect(excepttype, cp0_epc);
               end else begin
                  stall = stall_mask(stallreq_if, stallreq_id,
                                     stallreq_ex, stallreq_mem);
               end
            end
            DRAIN: begin
               if (stallreq_mem) begin
                  stall = STALL_MEM;
               end else begin
                  flush  = 1'b1;
                  new_pc = redirect(pend_code, pend_epc);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (rst_n == RST_ENABLE) begin
         state     <= RUN;
         pend_code <= ZERO_WORD;
         pend_epc  <= ZERO_WORD;
      end else begin
         unique case (state)
            RUN: begin
               if (exc && stallreq_mem) begin
                  pend_code <= excepttype;
                  pend_epc  <= cp0_epc;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (!stallreq_mem) begin
                  pend_code <= ZERO_WORD;
                  pend_epc  <= ZERO_WORD;
                  state     <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   pipe_ctrl_cnt u_cnt (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_any     (stall != STALL_NONE),
      .flush         (flush),
      .stall_cycles  (stall_cycles),
      .flush_count   (flush_count),
      .stall_timeout (stall_timeout)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst_n;
   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic [31:0] excepttype;
   logic [31:0] cp0_epc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;
   logic        stall_timeout;

   int errors = 0;
   int checks = 0;

   pipe_ctrl u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stallreq_if   (stallreq_if),
      .stallreq_id   (stallreq_id),
      .stallreq_ex   (stallreq_ex),
      .stallreq_mem  (stallreq_mem),
      .excepttype    (excepttype),
      .cp0_epc       (cp0_epc),
      .stall         (stall),
      .flush         (flush),
      .new_pc        (new_pc),
      .stall_cycles  (stall_cycles),
      .flush_count   (flush_count),
      .stall_timeout (stall_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic i_f, input logic i_d,
                        input logic i_e, input logic i_m,
                        input logic [31:0] code, input logic [31:0] epc);
      stallreq_if  = i_f;
      stallreq_id  = i_d;
      stallreq_ex  = i_e;
      stallreq_mem = i_m;
      excepttype   = code;
      cp0_epc      = epc;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 1, 32'h0c, 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_new_pc", new_pc, 32'h0);
      chk("rst_sc", stall_cycles, 32'h0);
      chk("rst_fc", 32'(flush_count), 32'h0);
      chk("rst_to", 32'(stall_timeout), 32'h0);
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      cyc();
      cyc();
      rst_n = 1'b1;

      // stall priority
      drive(1, 1, 0, 0, 32'h0, 32'h0);
      chk("id_if_stall", 32'(stall), 32'h07);
      chk("id_if_flush", 32'(flush), 32'h0);
      cyc();
      chk("id_if_sc", stall_cycles, 32'd1);
      drive(0, 0, 0, 1, 32'h0, 32'h0);
      chk("mem_stall", 32'(stall), 32'h1f);
      cyc();
      drive(0, 0, 1, 0, 32'h0, 32'h0);
      chk("ex_stall", 32'(stall), 32'h0f);
      cyc();
      drive(1, 0, 0, 0, 32'h0, 32'h0);
      chk("if_stall", 32'(stall), 32'h03);
      cyc();
      drive(1, 1, 1, 1, 32'h0, 32'h0);
      chk("all_stall", 32'(stall), 32'h1f);
      cyc();
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      chk("none_stall", 32'(stall), 32'h0);
      cyc();
      chk("prio_sc", stall_cycles, 32'd5);

      // immediate exception flush
      drive(0, 0, 0, 0, 32'h0c, 32'h0);
      chk("exc_flush", 32'(flush), 32'h1);
      chk("exc_new_pc", new_pc, 32'h20);
      chk("exc_stall", 32'(stall), 32'h0);
      cyc();
      chk("exc_fc", 32'(flush_count), 32'd1);
      drive(1, 1, 1, 0, 32'h04, 32'h0);
      chk("ovr_flush", 32'(flush), 32'h1);
      chk("ovr_stall", 32'(stall), 32'h0);
      cyc();
      chk("ovr_sc", stall_cycles, 32'd5);
      drive(0, 0, 0, 0, 32'h0e, 32'h0000_1234);
      chk("eret_new_pc", new_pc, 32'h0000_1234);
      cyc();
      chk("eret_fc", 32'(flush_count), 32'd3);

      // exception behind a busy data bus
      drive(0, 0, 0, 1, 32'h0e, 32'h0040_0100);
      chk("dr1_stall", 32'(stall), 32'h1f);
      chk("dr1_flush", 32'(flush), 32'h0);
      cyc();
      drive(0, 0, 0, 1, 32'h0c, 32'hdead_beef);
      chk("dr2_stall", 32'(stall), 32'h1f);
      chk("dr2_flush", 32'(flush), 32'h0);
      cyc();
      chk("dr3_stall", 32'(stall), 32'h1f);
      cyc();
      drive(0, 0, 1, 0, 32'h0, 32'h0);
      chk("dr_rel_flush", 32'(flush), 32'h1);
      chk("dr_rel_new_pc", new_pc, 32'h0040_0100);
      chk("dr_rel_stall", 32'(stall), 32'h0);
      cyc();
      chk("dr_fc", 32'(flush_count), 32'd4);
      chk("dr_sc", stall_cycles, 32'd8);
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      chk("dr_after_flush", 32'(flush), 32'h0);

      drive(0, 0, 0, 1, 32'h04, 32'h0000_5555);
      cyc();
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      chk("dr_vec_new_pc", new_pc, 32'h20);
      cyc();
      chk("dr_vec_fc", 32'(flush_count), 32'd5);
      chk("dr_vec_sc", stall_cycles, 32'd9);

      // reset while draining
      drive(0, 0, 0, 1, 32'h0c, 32'h0);
      cyc();
      rst_n = 1'b0;
      #1;
      chk("drst_sc", stall_cycles, 32'h0);
      chk("drst_fc", 32'(flush_count), 32'h0);
      chk("drst_stall", 32'(stall), 32'h0);
      cyc();
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      rst_n = 1'b1;
      #1;
      chk("drst_no_flush", 32'(flush), 32'h0);
      chk("drst_new_pc", new_pc, 32'h0);
      cyc();
      chk("drst_fc2", 32'(flush_count), 32'h0);
      chk("drst_sc2", stall_cycles, 32'h0);

      // counter boundaries
      force u_dut.u_cnt.stall_cycles = 32'hFFFF_FFFF;
      #1;
      release u_dut.u_cnt.stall_cycles;
      drive(1, 0, 0, 0, 32'h0, 32'h0);
      cyc();
      chk("sc_wrap", stall_cycles, 32'h0);
      force u_dut.u_cnt.flush_count = 16'hFFFF;
      #1;
      release u_dut.u_cnt.flush_count;
      drive(0, 0, 0, 0, 32'h0c, 32'h0);
      cyc();
      chk("fc_sat", 32'(flush_count), 32'h0000_FFFF);
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      cyc();

      // watchdog clears on a gap
      drive(0, 0, 1, 0, 32'h0, 32'h0);
      for (int i = 0; i < 600; i++) cyc();
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      cyc();
      drive(0, 0, 1, 0, 32'h0, 32'h0);
      for (int i = 0; i < 600; i++) cyc();
      chk("wd_gap_to", 32'(stall_timeout), 32'h0);
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      cyc();

      // watchdog limit
      drive(0, 0, 1, 0, 32'h0, 32'h0);
      for (int i = 0; i < 1022; i++) cyc();
      chk("wd_1022", 32'(stall_timeout), 32'h0);
      cyc();
      chk("wd_1023", 32'(stall_timeout), 32'h1);
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      cyc();
      chk("wd_sticky", 32'(stall_timeout), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("wd_rst", 32'(stall_timeout), 32'h0);
      rst_n = 1'b1;
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have: stallreq_if  in  1  fetch bus not ready; stallreq_id  in  1  load-use hazard; stallreq_ex  in  1  multi-cycle ALU/div busy; stallreq_mem  in  1  data bus transaction in flight.
REQ-003 SHALL have: excepttype  in  32  MEM-stage exception code, 0 = none; cp0_epc  in  32  EPC for eret.
REQ-004 SHALL have: stall  out  6  per-stage hold, bit0 PC .. bit5 WB, 1 = Stop; flush  out  1  kill all pipeline registers; new_pc  out  32  redirect target, valid when flush=1.
REQ-005 SHALL have: stall_cycles  out  32  total stalled cycles; flush_count  out  16  flushes taken; stall_timeout  out  1  sticky watchdog flag.

Function
REQ-006 Stall priority, highest wins: stallreq_mem -> 6'b011111; stallreq_ex -> 6'b001111; stallreq_id -> 6'b000111; stallreq_if -> 6'b000011; none -> 6'b000000.
REQ-007 stall, flush, new_pc SHALL be combinational from inputs and FSM state (zero-cycle latency); all other outputs registered.
REQ-008 FSM states: RUN, DRAIN.
REQ-009 RUN, excepttype!=0, stallreq_mem=0: flush=1, stall=0 same cycle; remain RUN; flush_count increments.
REQ-010 RUN, excepttype!=0, stallreq_mem=1: no flush; latch excepttype and cp0_epc into pending registers; stall=6'b011111; next state DRAIN.
REQ-011 DRAIN: stall=6'b011111 and all input excepttype ignored while stallreq_mem=1; first cycle stallreq_mem=0: flush=1, stall=0, new_pc from pending registers, flush_count increments, next state RUN.
REQ-012 new_pc: code 32'h0000000e (eret) -> EPC; any other nonzero code -> 32'h00000020; flush=0 -> 32'h0.
REQ-013 flush SHALL override every stall request; stall SHALL be 0 in any cycle flush=1.
REQ-014 stall_cycles increments by 1 each cycle stall!=0; wraps 32'hFFFFFFFF -> 0.
REQ-015 flush_count saturates at 16'hFFFF.
REQ-016 Watchdog: 10-bit counter of consecutive stall!=0 cycles, cleared on any stall=0 cycle; reaching 1023 sets stall_timeout, held until reset; counter saturates.
REQ-017 Stall requests in the flush cycle SHALL not be counted as stalled.

Reset
REQ-018 rst_n low SHALL asynchronously force state RUN, pending registers 0, stall_cycles 0, flush_count 0, watchdog 0, stall_timeout 0.
REQ-019 During reset stall=6'b000000, flush=0, new_pc=32'h0.
REQ-020 Reset asserted in DRAIN SHALL drop the pending exception; no flush after release.

Structure
REQ-021 Stop/NoStop, ZeroWord, RstEnable, exception codes (ExcEret), ExcVector 32'h00000020 and StallWdLimit 1023 SHALL live in defines.v.
REQ-022 Counters (stall_cycles, flush_count, watchdog) SHALL be one sub-module pipe_ctrl_cnt; FSM and stall/flush decode in pipe_ctrl.

Verification
REQ-023 stallreq_id=1 and stallreq_if=1 same cycle -> stall=6'b000111; stall_cycles +1.
REQ-024 excepttype=32'h0000000c, no stall -> same-cycle flush=1, new_pc=32'h00000020, stall=0, flush_count=1.
REQ-025 stallreq_mem=1 for 3 cycles with excepttype=32'h0e, cp0_epc=32'h00400100 -> stall=6'b011111 three cycles, then flush=1, new_pc=32'h00400100 on release cycle.
REQ-026 stallreq_ex held 1023 cycles -> stall_timeout=1 at cycle 1023, remains 1 after stallreq_ex drops.
REQ-027 Enter DRAIN, assert rst_n=0 one cycle, release with stallreq_mem=0 -> no flush, all counters 0.
REQ-028 Preload stall_cycles to 32'hFFFFFFFF (force), one stalled cycle -> 32'h0.
